// File: rtl/mips_alu_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: ALU function codes,
// sequencer state encoding and width helpers.
`ifndef MIPS_ALU_MULDIV_PROD_W
`define MIPS_ALU_MULDIV_PROD_W(w) (2 * (w))
`endif

package mips_alu_muldiv_pkg;

  typedef enum logic [4:0] {
    FN_ADD  = 5'd0,
    FN_ADDU = 5'd1,
    FN_SUB  = 5'd2,
    FN_SUBU = 5'd3,
    FN_AND  = 5'd4,
    FN_OR   = 5'd5,
    FN_XOR  = 5'd6,
    FN_NOR  = 5'd7,
    FN_SLT  = 5'd8,
    FN_SLTU = 5'd9,
    FN_SLL  = 5'd10,
    FN_SRL  = 5'd11,
    FN_SRA  = 5'd12,
    FN_LUI  = 5'd13,
    FN_MULS = 5'd14,
    FN_MULU = 5'd15,
    FN_DIVS = 5'd16,
    FN_DIVU = 5'd17,
    FN_MTHI = 5'd18,
    FN_MTLO = 5'd19,
    FN_MFHI = 5'd20,
    FN_MFLO = 5'd21
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_FIXUP = 2'd2
  } muldiv_state_e;

  // Ceiling log2, used to size the iteration counter.
  function automatic int log2_ceil(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_alu_div_step.sv
// One restoring-division iteration: shift remainder:quotient left by one and
// keep the trial subtraction when it does not borrow.
module mips_alu_div_step
  import mips_alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quo_in,
  input  logic [DATA_W-1:0] dvs_in,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quo_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // rem_in < dvs_in always holds, so a non-borrowing trial fits in DATA_W bits.
  always_comb begin
    shifted = {rem_in, quo_in[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_in};
    if (trial[DATA_W]) begin
      rem_out = shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b0};
    end else begin
      rem_out = trial[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mips_alu_muldiv.sv
// HI/LO owner: single-cycle MULT/MULTU, iterative restoring DIV/DIVU, MT/MF moves.
// Build option MIPS_ALU_MULDIV_EARLY_OUT_EN completes |dividend| < |divisor| at accept.
module mips_alu_muldiv
  import mips_alu_muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              op_valid,
  input  logic [FUNC_W-1:0] op_func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic              stall,
  output logic [DATA_W-1:0] reg_hi,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              div_zero
);

  localparam int CNT_W  = log2_ceil(DATA_W + 1);
  localparam int PROD_W = `MIPS_ALU_MULDIV_PROD_W(DATA_W);

  muldiv_state_e state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic              neg_q, rem_neg_q;

  logic              accept, is_signed;
  logic [DATA_W-1:0] mag1, mag2;
  logic [DATA_W-1:0] rem_next, quo_next;
  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;

  // Handshake: an op is taken on a cycle with op_valid high, the sequencer idle
  // and no flush; stall asks the pipeline to hold the op while a divide runs,
  // and is dropped when flush squashes the op instead.
  assign accept = op_valid && (state == ST_IDLE) && !flush;
  assign stall  = op_valid && (state != ST_IDLE) && !flush;
  assign busy   = (state != ST_IDLE);

  assign is_signed = (op_func == FUNC_W'(FN_DIVS));
  assign mag1 = (is_signed && data1[DATA_W-1]) ? -data1 : data1;
  assign mag2 = (is_signed && data2[DATA_W-1]) ? -data2 : data2;

  assign prod_s = $signed(data1) * $signed(data2);
  assign prod_u = {{DATA_W{1'b0}}, data1} * {{DATA_W{1'b0}}, data2};

  always_comb begin
    rd_data = '0;
    if (accept && op_func == FUNC_W'(FN_MFHI)) rd_data = reg_hi;
    if (accept && op_func == FUNC_W'(FN_MFLO)) rd_data = reg_lo;
  end

  mips_alu_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvs_in  (dvs_q),
    .rem_out (rem_next),
    .quo_out (quo_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      reg_hi    <= '0;
      reg_lo    <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op_func)
              FUNC_W'(FN_MULS): {reg_hi, reg_lo} <= prod_s;
              FUNC_W'(FN_MULU): {reg_hi, reg_lo} <= prod_u;
              FUNC_W'(FN_MTHI): reg_hi <= data1;
              FUNC_W'(FN_MTLO): reg_lo <= data1;
              FUNC_W'(FN_DIVS), FUNC_W'(FN_DIVU): begin
                if (data2 == '0) begin
                  reg_lo   <= '1;
                  reg_hi   <= data1;
                  div_zero <= 1'b1;
                end
`ifdef MIPS_ALU_MULDIV_EARLY_OUT_EN
                else if (mag1 < mag2) begin
                  reg_lo   <= '0;
                  reg_hi   <= data1;
                  div_zero <= 1'b0;
                end
`endif
                else begin
                  state     <= ST_DIV;
                  count     <= CNT_W'(DATA_W);
                  rem_q     <= '0;
                  quo_q     <= mag1;
                  dvs_q     <= mag2;
                  neg_q     <= is_signed && (data1[DATA_W-1] ^ data2[DATA_W-1]);
                  rem_neg_q <= is_signed && data1[DATA_W-1];
                end
              end
              default: ;
            endcase
          end
        end
        ST_DIV: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          state <= ST_IDLE;
          if (!flush) begin
            reg_lo   <= neg_q ? -quo_q : quo_q;
            reg_hi   <= rem_neg_q ? -rem_q : rem_q;
            div_zero <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_muldiv.sv
// Directed bench for mips_alu_muldiv: multiply, divide (signed/unsigned, zero,
// overflow), MT/MF moves, stall/busy timing, flush and reset aborts.
module tb_mips_alu_muldiv;
  import mips_alu_muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        op_valid;
  logic [4:0]  op_func;
  logic [31:0] data1, data2;
  logic        stall, busy, div_zero;
  logic [31:0] reg_hi, reg_lo, rd_data;

  int tests  = 0;
  int failed = 0;
  int busy_cycles;

  mips_alu_muldiv #(.DATA_W(32), .FUNC_W(5)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .op_valid (op_valid),
    .op_func  (op_func),
    .data1    (data1),
    .data2    (data2),
    .stall    (stall),
    .reg_hi   (reg_hi),
    .reg_lo   (reg_lo),
    .rd_data  (rd_data),
    .busy     (busy),
    .div_zero (div_zero)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one cycle at the falling edge; checks run 1 ns later, away from edges.
  task automatic cyc(input logic v, input logic [4:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic fl);
    @(negedge clock);
    op_valid = v;
    op_func  = f;
    data1    = a;
    data2    = b;
    flush    = fl;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, FN_ADD, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the accepting edge, then idle until the sequencer frees up.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    idle();
    while (busy && n < 100) begin
      idle();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    op_valid = 1'b0;
    op_func = FN_ADD;
    data1 = '0;
    data2 = '0;
    idle();
    idle();
    check("rst_hi", reg_hi, 32'd0);
    check("rst_lo", reg_lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    reset = 1'b0;

    // Multiplies
    cyc(1'b1, FN_MULU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mulu_stall", 32'(stall), 32'd0);
    idle();
    check("mulu_hi", reg_hi, 32'h0000_0001);
    check("mulu_lo", reg_lo, 32'hFFFF_FFFE);
    cyc(1'b1, FN_MULS, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle();
    check("muls_hi", reg_hi, 32'hFFFF_FFFF);
    check("muls_lo", reg_lo, 32'hFFFF_FFFE);
    cyc(1'b1, FN_MULS, 32'hFFFF_FFFD, 32'd5, 1'b0);
    idle();
    check("muls2_hi", reg_hi, 32'hFFFF_FFFF);
    check("muls2_lo", reg_lo, 32'hFFFF_FFF1);

    // Divs -7 / 2 with a back-to-back Mflo held under stall
    cyc(1'b1, FN_DIVS, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("divs_acc_stall", 32'(stall), 32'd0);
    cyc(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
    check("divs_stall", 32'(stall), 32'd1);
    check("divs_busy", 32'(busy), 32'd1);
    check("divs_rd_stalled", rd_data, 32'd0);
    busy_cycles = 1;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, FN_MFLO, 32'd0, 32'd0, 1'b0);
      if (!busy) break;
      busy_cycles++;
    end
    check("divs_busy_len", 32'(busy_cycles), 32'd33);
    check("mflo_stall", 32'(stall), 32'd0);
    check("mflo_rd", rd_data, 32'hFFFF_FFFD);
    check("divs_lo", reg_lo, 32'hFFFF_FFFD);
    check("divs_hi", reg_hi, 32'hFFFF_FFFF);
    idle();
    check("rd_idle", rd_data, 32'd0);

    // Divs 7 / -2: remainder follows the dividend sign
    cyc(1'b1, FN_DIVS, 32'd7, 32'hFFFF_FFFE, 1'b0);
    wait_done("divs2_done");
    check("divs2_lo", reg_lo, 32'hFFFF_FFFD);
    check("divs2_hi", reg_hi, 32'd1);

    // Divide by zero, then a normal divide clears the flag
    cyc(1'b1, FN_DIVU, 32'd100, 32'd0, 1'b0);
    check("dz_stall", 32'(stall), 32'd0);
    idle();
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_lo", reg_lo, 32'hFFFF_FFFF);
    check("dz_hi", reg_hi, 32'd100);
    check("dz_flag", 32'(div_zero), 32'd1);
    cyc(1'b1, FN_DIVU, 32'd9, 32'd3, 1'b0);
    wait_done("divu_done");
    check("divu_lo", reg_lo, 32'd3);
    check("divu_hi", reg_hi, 32'd0);
    check("divu_dz_clr", 32'(div_zero), 32'd0);

    cyc(1'b1, FN_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_done("divu2_done");
    check("divu2_lo", reg_lo, 32'h0FFF_FFFF);
    check("divu2_hi", reg_hi, 32'h0000_000F);

    // Signed overflow case wraps
    cyc(1'b1, FN_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("ovf_done");
    check("ovf_lo", reg_lo, 32'h8000_0000);
    check("ovf_hi", reg_hi, 32'd0);
    check("ovf_dz", 32'(div_zero), 32'd0);

    // Moves
    cyc(1'b1, FN_MTHI, 32'h1111_1111, 32'd0, 1'b0);
    cyc(1'b1, FN_MTLO, 32'h2222_2222, 32'd0, 1'b0);
    idle();
    check("mthi", reg_hi, 32'h1111_1111);
    check("mtlo", reg_lo, 32'h2222_2222);
    cyc(1'b1, FN_MFHI, 32'd0, 32'd0, 1'b0);
    check("mfhi_rd", rd_data, 32'h1111_1111);
    cyc(1'b1, FN_MTLO, 32'h3333_3333, 32'd0, 1'b1);
    idle();
    check("flush_idle_lo", reg_lo, 32'h2222_2222);

    // Flush at cycle 10 of a divide, together with an Mthi
    cyc(1'b1, FN_DIVU, 32'd50, 32'd7, 1'b0);
    for (int i = 1; i < 10; i++) idle();
    cyc(1'b1, FN_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
    check("flush_busy", 32'(busy), 32'd1);
    check("flush_stall", 32'(stall), 32'd0);
    idle();
    check("flush_busy_drop", 32'(busy), 32'd0);
    check("flush_hi", reg_hi, 32'h1111_1111);
    check("flush_lo", reg_lo, 32'h2222_2222);
    for (int i = 0; i < 40; i++) idle();
    check("flush_hi_late", reg_hi, 32'h1111_1111);
    check("flush_lo_late", reg_lo, 32'h2222_2222);

    // Reset mid-divide
    cyc(1'b1, FN_DIVU, 32'd50, 32'd7, 1'b0);
    for (int i = 0; i < 5; i++) idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    idle();
    check("rstdiv_busy", 32'(busy), 32'd0);
    check("rstdiv_hi", reg_hi, 32'd0);
    check("rstdiv_lo", reg_lo, 32'd0);

    // Small dividend: early-out build completes at accept, others take full latency
    cyc(1'b1, FN_DIVU, 32'd3, 32'd10, 1'b0);
    check("eo_stall", 32'(stall), 32'd0);
`ifdef MIPS_ALU_MULDIV_EARLY_OUT_EN
    idle();
    check("eo_busy", 32'(busy), 32'd0);
    check("eo_lo", reg_lo, 32'd0);
    check("eo_hi", reg_hi, 32'd3);
`else
    wait_done("eo_done");
    check("eo_lo", reg_lo, 32'd0);
    check("eo_hi", reg_hi, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mips_alu_muldiv.md
Name: mips_alu_muldiv

Overview:
- Sequencer for the HI/LO multiply/divide resource beside the single-cycle ALU. Runs MULT/MULTU in one cycle and DIV/DIVU as an iterative restoring divider. Owns the architectural HI/LO registers.
- Execute stage issues ops to it; the block back-pressures the pipeline via stall while a divide is in flight.
- MFHI/MFLO and MTHI/MTLO are serialized behind any in-flight divide.

Parameters:
- DATA_W, 32, operand/HI/LO width; power of two, >= 8
- FUNC_W, 5, width of op_func, matching the ALU function encoding

Ports:
- clock  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  abort in-flight divide (pipeline squash)
- op_valid  input  1  op_func/data1/data2 valid this cycle
- op_func  input  FUNC_W  ALU function code; only Muls, Mulu, Divs, Divu, Mthi, Mtlo, Mfhi, Mflo are acted on
- data1  input  DATA_W  rs operand / dividend / multiplicand / MT source
- data2  input  DATA_W  rt operand / divisor / multiplier
- stall  output  1  op_valid not accepted this cycle; hold inputs
- reg_hi  output  DATA_W  architectural HI
- reg_lo  output  DATA_W  architectural LO
- rd_data  output  DATA_W  MFHI/MFLO result, valid when op_valid && !stall
- busy  output  1  divide in progress
- div_zero  output  1  sticky: last completed divide had data2 == 0

Behaviour:
- Reset: state IDLE; reg_hi = reg_lo = 0; busy = 0; stall = 0; div_zero = 0. Reset during a divide aborts it; HI/LO are cleared.
- Accept: an op is accepted when op_valid && state == IDLE && !flush. stall = op_valid && state != IDLE. Non-HI/LO funcs are always accepted as no-ops; stall is still raised for them while busy.
- Muls/Mulu: HI:LO = signed/unsigned 2*DATA_W product, written at the accepting edge. Next cycle reads the new value.
- Mthi/Mtlo: write data1 to HI/LO at the accepting edge.
- Mfhi/Mflo: rd_data = reg_hi/reg_lo combinationally in the accepting cycle. rd_data = 0 otherwise.
- Div/Divu, data2 != 0:
  - IDLE -> DIV: latch magnitudes (signed) or raw operands (unsigned) and both sign bits; clear partial remainder; count = DATA_W.
  - DIV: one restoring step per cycle (shift remainder:quotient left, trial-subtract divisor, keep if non-negative). Decrement count; at count == 1 go to FIXUP.
  - FIXUP: quotient negated iff signs differ (signed only); remainder takes the dividend sign. Write LO = quotient, HI = remainder; clear div_zero; go to IDLE.
  - Latency: accept edge + DATA_W DIV cycles + 1 FIXUP cycle. HI/LO are visible DATA_W+2 cycles after accept. busy is high throughout DIV and FIXUP.
- Div/Divu, data2 == 0: complete at the accepting edge with LO = all ones, HI = data1; set div_zero; no stall.
- Signed -2^(DATA_W-1) / -1: LO = -2^(DATA_W-1) (wraps), HI = 0; no flag.
- flush: in DIV/FIXUP, return to IDLE next edge; HI/LO unchanged. flush has priority over op_valid in the same cycle (op ignored, stall = 0). flush in IDLE has no effect.
- FIXUP -> IDLE and an op presented in the FIXUP cycle: the op is stalled that cycle and accepted the following cycle.

Optional Feature:
- Macro: MIPS_ALU_MULDIV_EARLY_OUT_EN
- Defined: at accept, if |dividend| < |divisor| (unsigned compare of latched magnitudes), skip DIV and complete at the accepting edge with LO = 0, HI = data1; zero latency, no stall.
- Undefined: every nonzero-divisor divide takes the full DATA_W+2 cycles.

Decomposition:
- Shared package: ALU function encodings (existing Func definitions), muldiv state encoding (IDLE/DIV/FIXUP), a log2 helper for counter width, and the DATA_W-derived width macros.
- Sub-module mips_alu_div_step: combinational single restoring iteration (remainder, quotient, divisor in; next remainder, next quotient out). Instantiated once and registered by the FSM.

Test Plan:
- Reset, then Mulu 0xFFFFFFFF * 2 -> next cycle HI = 0x00000001, LO = 0xFFFFFFFE; Muls 0xFFFFFFFF * 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- Divs -7 / 2 -> busy for 33 cycles, stall on a back-to-back Mflo; then LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1); Mflo rd_data = 0xFFFFFFFD.
- Divu 100 / 0 -> no stall, LO = 0xFFFFFFFF, HI = 100, div_zero = 1; subsequent Divu 9 / 3 clears div_zero, LO = 3, HI = 0.
- Divs 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- Start Divu 50 / 7, assert flush at cycle 10 together with op_valid Mthi -> busy drops next edge, Mthi ignored, HI/LO keep pre-divide values.
- Assert reset mid-divide -> HI = LO = 0, busy = 0 next cycle. With MIPS_ALU_MULDIV_EARLY_OUT_EN, Divu 3 / 10 -> LO = 0, HI = 3 with no stall.
